// File: rtl/nios2_mul_seq_pkg.sv
// Shared state encoding and widths for the multiplier-cell sequencer.
package nios2_mul_seq_pkg;

  localparam int PROD_W = 64;
  localparam int HALF_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ISSUE    = 3'd1,
    ST_SUM      = 3'd2,
    ST_ISSUE_HI = 3'd3,
    ST_SUM_HI   = 3'd4,
    ST_RESP     = 3'd5
  } state_t;

endpackage

// File: rtl/nios2_mul_rr_arbiter.sv
// Round-robin arbiter: first valid requester at or after the pointer wins;
// the pointer moves past the winner only when the grant is accepted.
module nios2_mul_rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] i_valid,
  input  logic               i_accept,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [ID_W-1:0]    o_idx,
  output logic               o_any
);

  logic [ID_W-1:0] r_ptr;
  logic [ID_W-1:0] w_idx;
  logic [ID_W-1:0] w_sel;
  logic            w_any;
  int              w_pos;

  // search from the pointer with wrap
  always_comb begin
    w_idx = '0;
    w_any = 1'b0;
    w_sel = '0;
    w_pos = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_pos = int'(r_ptr) + k;
      w_pos = (w_pos >= NUM_REQ) ? (w_pos - NUM_REQ) : w_pos;
      w_sel = ID_W'(w_pos);
      w_idx = (i_valid[w_sel] && !w_any) ? w_sel : w_idx;
      w_any = w_any | i_valid[w_sel];
    end
  end

  assign o_idx   = w_idx;
  assign o_any   = w_any;
  assign o_grant = w_any ? (NUM_REQ'(1) << w_idx) : '0;

  // pointer advances to the slot after an accepted winner
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr <= '0;
    end else if (i_accept) begin
      r_ptr <= (int'(w_idx) == NUM_REQ - 1) ? '0 : (w_idx + ID_W'(1));
    end
  end

endmodule

// File: rtl/nios2_mul_cell_sequencer.sv
// Shares one 3-product 16x16 multiplier cell among NUM_REQ requesters.
// Optional 64-bit product via macro MUL_HI_EN (extra Ahi*Bhi pass through the cell).
module nios2_mul_cell_sequencer
  import nios2_mul_seq_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [32*NUM_REQ-1:0] req_src1,
  input  logic [32*NUM_REQ-1:0] req_src2,
  input  logic [NUM_REQ-1:0]   req_hi,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [31:0]          rsp_lo,
  output logic [31:0]          rsp_hi,
  output logic [31:0]          mc_src1,
  output logic [31:0]          mc_src2,
  output logic                 mc_en,
  input  logic [31:0]          mc_p1,
  input  logic [31:0]          mc_p2,
  input  logic [31:0]          mc_p3
);

  state_t              r_state;
  state_t              w_next;
  logic [NUM_REQ-1:0]  w_grant;
  logic [ID_W-1:0]     w_idx;
  logic                w_any;
  logic                w_accept;
  logic                w_hi_pass;
  logic [32:0]         w_mid;
  logic [PROD_W-1:0]   w_lo64;
  logic [31:0]         r_mc_src1;
  logic [31:0]         r_mc_src2;
  logic                r_mc_en;
  logic                r_rsp_valid;
  logic [ID_W-1:0]     r_rsp_id;
  logic [31:0]         r_rsp_lo;

  nios2_mul_rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_valid  (req_valid),
    .i_accept (w_accept),
    .o_grant  (w_grant),
    .o_idx    (w_idx),
    .o_any    (w_any)
  );

  assign w_accept  = (r_state == ST_IDLE) && w_any;
  assign req_ready = (w_accept && reset_n) ? w_grant : '0;

  // the cross-term sum keeps its carry before the 16-bit shift
  assign w_mid  = {1'b0, mc_p2} + {1'b0, mc_p3};
  assign w_lo64 = {32'd0, mc_p1} + ({31'd0, w_mid} << HALF_W);

`ifdef MUL_HI_EN
  logic        r_hi;
  logic [31:0] r_rsp_hi;
  assign w_hi_pass = r_hi;
  assign rsp_hi    = r_rsp_hi;
`else
  logic w_unused_hi;
  assign w_hi_pass   = 1'b0;
  assign rsp_hi      = 32'd0;
  assign w_unused_hi = ^{req_hi, w_lo64[63:32]};
`endif

  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:     w_next = w_any ? ST_ISSUE : ST_IDLE;
      ST_ISSUE:    w_next = ST_SUM;
      ST_SUM:      w_next = w_hi_pass ? ST_ISSUE_HI : ST_RESP;
`ifdef MUL_HI_EN
      ST_ISSUE_HI: w_next = ST_SUM_HI;
      ST_SUM_HI:   w_next = ST_RESP;
`endif
      ST_RESP:     w_next = rsp_ready ? ST_IDLE : ST_RESP;
      default:     w_next = ST_IDLE;
    endcase
  end

  // operand issue, product capture and response hold
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mc_src1   <= 32'd0;
      r_mc_src2   <= 32'd0;
      r_mc_en     <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_lo    <= 32'd0;
`ifdef MUL_HI_EN
      r_hi        <= 1'b0;
      r_rsp_hi    <= 32'd0;
`endif
    end else begin
      r_mc_en     <= (w_next == ST_ISSUE) || (w_next == ST_ISSUE_HI);
      r_rsp_valid <= (w_next == ST_RESP);
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_mc_src1 <= req_src1[32*int'(w_idx) +: 32];
            r_mc_src2 <= req_src2[32*int'(w_idx) +: 32];
            r_rsp_id  <= w_idx;
`ifdef MUL_HI_EN
            r_hi      <= req_hi[w_idx];
`endif
          end
        end
        ST_SUM: begin
          r_rsp_lo <= w_lo64[31:0];
`ifdef MUL_HI_EN
          r_rsp_hi  <= w_hi_pass ? w_lo64[63:32] : 32'd0;
          r_mc_src1 <= {16'd0, r_mc_src1[31:16]};
          r_mc_src2 <= {16'd0, r_mc_src2[31:16]};
`endif
        end
`ifdef MUL_HI_EN
        ST_SUM_HI: begin
          r_rsp_hi <= r_rsp_hi + mc_p1;
        end
`endif
        default: begin
        end
      endcase
    end
  end

  assign mc_src1   = r_mc_src1;
  assign mc_src2   = r_mc_src2;
  assign mc_en     = r_mc_en;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_lo    = r_rsp_lo;

endmodule

// File: tb/tb_nios2_mul_cell_sequencer.sv
// Bench for nios2_mul_cell_sequencer: behavioural cell + transaction model
// checked every cycle, plus hand-computed expectations for directed vectors.
module tb_nios2_mul_cell_sequencer;

  localparam int N  = 2;
  localparam int IW = 1;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_ready;
  logic [32*N-1:0] req_src1;
  logic [32*N-1:0] req_src2;
  logic [N-1:0]  req_hi;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [IW-1:0] rsp_id;
  logic [31:0]   rsp_lo;
  logic [31:0]   rsp_hi;
  logic [31:0]   mc_src1;
  logic [31:0]   mc_src2;
  logic          mc_en;
  logic [31:0]   mc_p1 = 32'd0;
  logic [31:0]   mc_p2 = 32'd0;
  logic [31:0]   mc_p3 = 32'd0;

  nios2_mul_cell_sequencer #(.NUM_REQ(N), .ID_W(IW)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_src1(req_src1), .req_src2(req_src2), .req_hi(req_hi),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_lo(rsp_lo), .rsp_hi(rsp_hi), .mc_src1(mc_src1), .mc_src2(mc_src2),
    .mc_en(mc_en), .mc_p1(mc_p1), .mc_p2(mc_p2), .mc_p3(mc_p3)
  );

  always #5 clk = ~clk;

  // multiplier cell: products registered when enabled, held otherwise
  always @(posedge clk) begin
    if (mc_en) begin
      mc_p1 <= 32'(mc_src1[15:0]) * 32'(mc_src2[15:0]);
      mc_p2 <= 32'(mc_src1[15:0]) * 32'(mc_src2[31:16]);
      mc_p3 <= 32'(mc_src1[31:16]) * 32'(mc_src2[15:0]);
    end
  end

  typedef struct {
    int          id;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] lo;
    logic [31:0] hi;
    bit          hp;
    int          acc;
  } op_t;

  op_t         q[$];
  int          gseq[$];
  logic [31:0] lo_log[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          ptr = 0;
  int          hs_cyc = 0;
  int          acc_cyc = 0;
  int          n_rsp = 0;
  int          last_lat = 0;
  int          last_id = 0;
  logic [31:0] last_lo = 32'd0;
  logic [31:0] last_hi = 32'd0;
  bit          seen_v = 1'b0;
  bit          busy;
  bit          ev;
  bit          emc;
  int          w;
  logic [N-1:0] eg;
  logic [63:0] prod;
  op_t         o;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // transaction model and per-cycle compare
  always @(negedge clk) begin
    if (!reset_n) begin
      q.delete();
      ptr    = 0;
      seen_v = 1'b0;
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_mc_en", mc_en, 0);
      chk("rst_mc_src1", mc_src1, 0);
      chk("rst_mc_src2", mc_src2, 0);
      chk("rst_rsp_id", rsp_id, 0);
      chk("rst_rsp_lo", rsp_lo, 0);
      chk("rst_rsp_hi", rsp_hi, 0);
    end else begin
      busy = (q.size() != 0);
      ev   = 1'b0;
      emc  = 1'b0;
      if (busy) begin
        ev  = (cyc >= q[0].acc + (q[0].hp ? 5 : 3));
        emc = (cyc == q[0].acc + 1) || (q[0].hp && (cyc == q[0].acc + 3));
      end
      chk("rsp_valid", rsp_valid, ev);
      chk("mc_en", mc_en, emc);
      if (busy && emc && (cyc == q[0].acc + 1)) begin
        chk("mc_src1", mc_src1, q[0].a);
        chk("mc_src2", mc_src2, q[0].b);
      end
      if (busy && emc && (cyc == q[0].acc + 3)) begin
        chk("mc_src1_hi", mc_src1, {16'h0, q[0].a[31:16]});
        chk("mc_src2_hi", mc_src2, {16'h0, q[0].b[31:16]});
      end
      if (busy && ev && rsp_valid) begin
        chk("rsp_id", rsp_id, q[0].id);
        chk("rsp_lo", rsp_lo, q[0].lo);
        chk("rsp_hi", rsp_hi, q[0].hi);
        if (!seen_v) begin
          last_lat = cyc - q[0].acc;
          seen_v   = 1'b1;
        end
        if (rsp_ready) begin
          last_lo = rsp_lo;
          last_hi = rsp_hi;
          last_id = int'(rsp_id);
          lo_log.push_back(rsp_lo);
          hs_cyc = cyc;
          n_rsp++;
          seen_v = 1'b0;
          void'(q.pop_front());
        end
      end
      eg = '0;
      w  = -1;
      if (!busy && (req_valid != '0)) begin
        for (int k = 0; k < N; k++) begin
          if (w < 0 && req_valid[(ptr + k) % N]) w = (ptr + k) % N;
        end
        eg[w] = 1'b1;
      end
      chk("req_ready", req_ready, eg);
      if (w >= 0) begin
        o.id  = w;
        o.a   = req_src1[32*w +: 32];
        o.b   = req_src2[32*w +: 32];
        prod  = {32'd0, o.a} * {32'd0, o.b};
`ifdef MUL_HI_EN
        o.hp  = req_hi[w];
`else
        o.hp  = 1'b0;
`endif
        o.lo  = prod[31:0];
        o.hi  = o.hp ? prod[63:32] : 32'd0;
        o.acc = cyc;
        q.push_back(o);
        gseq.push_back(w);
        acc_cyc = cyc;
        ptr = (w + 1) % N;
      end
    end
  end

  task automatic do_op(input int i, input logic [31:0] a, input logic [31:0] b, input logic h);
    int t;
    @(posedge clk); #1;
    req_src1[32*i +: 32] = a;
    req_src2[32*i +: 32] = b;
    req_hi[i]    = h;
    req_valid[i] = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!req_ready[i] && t < 50);
    chk("grant_seen", req_ready[i], 1);
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
  endtask

  task automatic wait_rsp(input int target);
    int t;
    t = 0;
    while (n_rsp < target && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("rsp_count", n_rsp, target);
  endtask

  task automatic wait_grants(input int target);
    int t;
    t = 0;
    while (gseq.size() < target && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("grant_count", gseq.size(), target);
  endtask

  initial begin
    int base;
    int gb;
    int t;
    reset_n   = 1'b0;
    req_valid = '0;
    req_src1  = '0;
    req_src2  = '0;
    req_hi    = '0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    base = n_rsp;
    do_op(0, 32'h0001_0002, 32'h0003_0004, 1'b0);
    wait_rsp(base + 1);
    chk("t1_lo", last_lo, 32'h000A_0008);
    chk("t1_id", last_id, 0);
    chk("t1_lat", last_lat, 3);
    chk("t1_hi", last_hi, 32'h0);

    base = n_rsp;
    do_op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    wait_rsp(base + 1);
    chk("t2_lo", last_lo, 32'h0000_0001);
`ifdef MUL_HI_EN
    chk("t2_hi", last_hi, 32'hFFFF_FFFE);
    chk("t2_lat", last_lat, 5);
`else
    chk("t2_hi", last_hi, 32'h0);
    chk("t2_lat", last_lat, 3);
`endif

    base = n_rsp;
    do_op(1, 32'h0000_FFFF, 32'h0001_0001, 1'b0);
    wait_rsp(base + 1);
    chk("t3_lo", last_lo, 32'hFFFF_FFFF);
    chk("t3_id", last_id, 1);

    // both requesters held valid: grants must alternate
    base = n_rsp;
    gb = gseq.size();
    @(posedge clk); #1;
    req_src1  = {32'h0001_0000, 32'h0000_0003};
    req_src2  = {32'h0001_0000, 32'h0000_0005};
    req_hi    = '0;
    req_valid = 2'b11;
    wait_grants(gb + 4);
    @(posedge clk); #1;
    req_valid = '0;
    wait_rsp(base + 4);
    chk("t4_g0", gseq[gb + 0], 0);
    chk("t4_g1", gseq[gb + 1], 1);
    chk("t4_g2", gseq[gb + 2], 0);
    chk("t4_g3", gseq[gb + 3], 1);
    chk("t4_lo0", lo_log[base + 0], 32'd15);
    chk("t4_lo1", lo_log[base + 1], 32'd0);

    // consumer stalls in RESP with another request pending
    base = n_rsp;
    gb = gseq.size();
    rsp_ready = 1'b0;
    @(posedge clk); #1;
    req_src1  = {32'h0000_0009, 32'h0000_0007};
    req_src2  = {32'h0000_000B, 32'h0000_0006};
    req_valid = 2'b11;
    wait_grants(gb + 1);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    t = 0;
    while (!rsp_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    repeat (5) @(negedge clk);
    chk("t5_stall_valid", rsp_valid, 1);
    chk("t5_stall_ready", req_ready, 0);
    chk("t5_stall_mc_en", mc_en, 0);
    chk("t5_stall_lo", rsp_lo, 32'd42);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    wait_grants(gb + 2);
    chk("t5_regrant_gap", acc_cyc - hs_cyc, 1);
    chk("t5_regrant_id", gseq[gb + 1], 1);
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    wait_rsp(base + 2);
    chk("t5_lo1", last_lo, 32'd99);

    // reset during SUM discards the op and restores the pointer
    base = n_rsp;
    do_op(0, 32'h1111_1111, 32'h0000_0002, 1'b0);
    @(posedge clk); #1;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    gb = gseq.size();
    req_src1  = {32'h0000_0003, 32'h0000_1234};
    req_src2  = {32'h0000_0007, 32'h0000_0010};
    req_valid = 2'b11;
    wait_grants(gb + 1);
    chk("t6_rr_reset", gseq[gb], 0);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    wait_grants(gb + 2);
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    wait_rsp(base + 2);
    chk("t6_lo0", lo_log[base + 0], 32'h0001_2340);
    chk("t6_lo1", last_lo, 32'h0000_0015);
    chk("t6_id1", last_id, 1);

    repeat (5) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached (compared %0d, mismatched %0d)", n_cmp, n_bad);
    $fatal(1);
  end

endmodule
